// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Owns the single register-file write port behind the writeback stage and
//   shares it between the in-order pipeline WB result and out-of-order
//   multiply/divide (MDU) results.
//   - Pipeline writes have priority.
//   - MDU results are queued in a small FIFO and drain into idle port cycles.
//   - When the FIFO head has been denied MAX_WAIT consecutive cycles, the
//     pipeline is stalled for one cycle and the head is forced onto the port.
//
// Optional feature:
//   WB_ARB_BYPASS_EN (macro) - when defined, an MDU result accepted while the
//   FIFO is empty and the pipeline is not writing goes straight to the port
//   (latency 1) without being stored.
//
// Parameters:
//   DEPTH     MDU FIFO entries (power of 2, 2..16)
//   MAX_WAIT  consecutive denied cycles before a forced grant (1..15)
//   DATA_W    write data width
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pipe_we/pipe_rd/pipe_data     WB stage write request
//   mdu_valid/mdu_rd/mdu_data     MDU result offer
//   mdu_ready                     FIFO can accept (combinational)
//   pipe_stall                    pipeline must hold WB this cycle (combinational)
//   rf_we/rf_waddr/rf_wdata       registered register-file write port
//   fifo_count                    entries currently queued
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_rd,
    input  logic [DATA_W-1:0]          pipe_data,
    input  logic                       mdu_valid,
    input  logic [4:0]                 mdu_rd,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       mdu_ready,
    output logic                       pipe_stall,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 5;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [3:0]       WAIT_LIM  = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_FORCE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [ENT_W-1:0]   r_mem [DEPTH];   // {rd, data}
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [3:0]         r_wait;

    logic               w_pipe_req;
    logic               w_accept;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_grant_pipe;
    logic [CNT_W-1:0]   w_count_next;
    logic [3:0]         w_wait_inc;

    // Writes to $0 are architecturally discarded, so they never claim the port.
    assign w_pipe_req = pipe_we && (pipe_rd != 5'd0);

    assign mdu_ready  = !rst && (r_count < DEPTH_CNT);
    assign pipe_stall = !rst && (r_state == ST_FORCE);
    assign w_accept   = mdu_valid && mdu_ready;

`ifdef WB_ARB_BYPASS_EN
    assign w_bypass = w_accept && (r_state == ST_EMPTY) && !w_pipe_req
                      && (mdu_rd != 5'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // $0 results are handshaken away but never occupy a FIFO slot.
    assign w_push = w_accept && (mdu_rd != 5'd0) && !w_bypass;

    // In FORCE the pipeline is stalled, so its request is not serviced.
    assign w_grant_pipe = w_pipe_req && (r_state != ST_FORCE);
    assign w_pop        = (r_state == ST_FORCE)
                       || ((r_state == ST_PENDING) && !w_pipe_req);

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_wait_inc   = r_wait + 4'd1;

    assign fifo_count = r_count;

    // FIFO storage: no reset so it maps onto RAM; stale contents are harmless
    // because the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {mdu_rd, mdu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wait   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // Write port: address/data hold when nothing is granted.
            rf_we <= w_grant_pipe || w_pop || w_bypass;
            if (w_grant_pipe) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end else if (w_pop) begin
                {rf_waddr, rf_wdata} <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                rf_waddr <= mdu_rd;
                rf_wdata <= mdu_data;
            end

            // Power-of-2 depth lets the pointers wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;

            case (r_state)
                ST_EMPTY: begin
                    r_wait <= '0;
                    if (w_push) r_state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (w_pipe_req) begin
                        // Head is eligible (pushed in an earlier cycle) and denied.
                        r_wait <= w_wait_inc;
                        if (w_wait_inc >= WAIT_LIM) r_state <= ST_FORCE;
                    end else begin
                        r_wait <= '0;
                        if (w_count_next == '0) r_state <= ST_EMPTY;
                    end
                end
                ST_FORCE: begin
                    r_wait  <= '0;
                    r_state <= (w_count_next == '0) ? ST_EMPTY : ST_PENDING;
                end
                default: begin
                    r_wait  <= '0;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(3), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        idle_inputs();
        tick(); tick();
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_mdu_ready: got %0b want 0", mdu_ready); end
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", pipe_stall); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_addr_data: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        rst = 0;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL idle_mdu_ready: got %0b want 1", mdu_ready); end
        $display("reset: done");
    endtask

    task automatic test_pipe_write;
        pipe_we = 1; pipe_rd = 5'd8; pipe_data = 32'h34877329;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h34877329) begin errors++; $display("FAIL pipe_write: got we=%0b rd=%0d d=%h want 1/8/34877329", rf_we, rf_waddr, rf_wdata); end
        pipe_we = 0; pipe_rd = 5'd9; pipe_data = 32'hFFFF0000;
        tick();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd8 || rf_wdata !== 32'h34877329) begin errors++; $display("FAIL pipe_hold: got we=%0b rd=%0d d=%h want 0/8/34877329", rf_we, rf_waddr, rf_wdata); end
        $display("pipe_write: rd=8 data=34877329");
    endtask

    task automatic test_zero_filter;
        pipe_we = 1; pipe_rd = 5'd0; pipe_data = 32'hAAAA5555;
        mdu_valid = 1; mdu_rd = 5'd0; mdu_data = 32'h5555AAAA;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL zero_mdu_ready: got %0b want 1", mdu_ready); end
        tick();
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL zero_filter_c0: got we=%0b cnt=%0d want 0/0", rf_we, fifo_count); end
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL zero_filter_c1: got we=%0b cnt=%0d want 0/0", rf_we, fifo_count); end
        $display("zero_filter: rd=0 writes dropped");
    endtask

    task automatic test_queue_drain;
        pipe_we = 1; pipe_rd = 5'd1; pipe_data = 32'hA1A1A1A1;
        mdu_valid = 1; mdu_rd = 5'd5; mdu_data = 32'h12345678;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || fifo_count !== 3'd1) begin errors++; $display("FAIL qd_c0: got we=%0b rd=%0d cnt=%0d want 1/1/1", rf_we, rf_waddr, fifo_count); end
        pipe_rd = 5'd2; pipe_data = 32'hA2A2A2A2;
        mdu_rd = 5'd6; mdu_data = 32'h87654321;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'hA2A2A2A2 || fifo_count !== 3'd2) begin errors++; $display("FAIL qd_c1: got we=%0b rd=%0d d=%h cnt=%0d want 1/2/a2a2a2a2/2", rf_we, rf_waddr, rf_wdata, fifo_count); end
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678 || fifo_count !== 3'd1) begin errors++; $display("FAIL qd_pop5: got we=%0b rd=%0d d=%h cnt=%0d want 1/5/12345678/1", rf_we, rf_waddr, rf_wdata, fifo_count); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h87654321 || fifo_count !== 3'd0) begin errors++; $display("FAIL qd_pop6: got we=%0b rd=%0d d=%h cnt=%0d want 1/6/87654321/0", rf_we, rf_waddr, rf_wdata, fifo_count); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL qd_idle: got we=%0b want 0", rf_we); end
        $display("queue_drain: rd5 then rd6 written in order");
    endtask

    task automatic test_starvation;
        pipe_we = 1; pipe_rd = 5'd10; pipe_data = 32'hB0000010;
        mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h748230a5;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10) begin errors++; $display("FAIL starve_c0: got we=%0b rd=%0d want 1/10", rf_we, rf_waddr); end
        mdu_valid = 0;
        for (int i = 1; i < 4; i++) begin
            pipe_rd = 5'(10 + i); pipe_data = 32'hB0000010 + 32'(i);
            #1;
            checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_nostall%0d: got %0b want 0", i, pipe_stall); end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== 32'hB0000010 + 32'(i)) begin errors++; $display("FAIL starve_pipe%0d: got we=%0b rd=%0d d=%h want 1/%0d", i, rf_we, rf_waddr, rf_wdata, 10 + i); end
        end
        pipe_rd = 5'd14; pipe_data = 32'hB0000014;
        #1;
        checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %0b want 1", pipe_stall); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h748230a5) begin errors++; $display("FAIL starve_force: got we=%0b rd=%0d d=%h want 1/9/748230a5", rf_we, rf_waddr, rf_wdata); end
        #1;
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_stall_once: got %0b want 0", pipe_stall); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd14 || rf_wdata !== 32'hB0000014) begin errors++; $display("FAIL starve_held: got we=%0b rd=%0d d=%h want 1/14/b0000014", rf_we, rf_waddr, rf_wdata); end
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL starve_end: got we=%0b cnt=%0d want 0/0", rf_we, fifo_count); end
        $display("starvation: forced grant of rd9 after 3 denials");
    endtask

    task automatic test_full;
        logic [31:0] d [4];
        d[0] = 32'hC0DE0000; d[1] = 32'hC0DE1111; d[2] = 32'hC0DE2222; d[3] = 32'hC0DE3333;
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1; pipe_rd = 5'(20 + i); pipe_data = 32'(i);
            mdu_valid = 1; mdu_rd = 5'(16 + i); mdu_data = d[i];
            tick();
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        pipe_we = 0; mdu_valid = 1; mdu_rd = 5'd31; mdu_data = 32'hDEADBEEF;
        #1;
        checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", mdu_ready); end
        tick();
        mdu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd16 || rf_wdata !== d[0] || fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop0: got we=%0b rd=%0d d=%h cnt=%0d want 1/16/%h/3", rf_we, rf_waddr, rf_wdata, fifo_count, d[0]); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %0b want 1", mdu_ready); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(16 + i) || rf_wdata !== d[i]) begin errors++; $display("FAIL full_pop%0d: got we=%0b rd=%0d d=%h want 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 16 + i, d[i]); end
        end
        tick();
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL full_end: got we=%0b cnt=%0d want 0/0", rf_we, fifo_count); end
        $display("full: 4 entries drained in order, rd31 ignored");
    endtask

    task automatic test_push_pop;
        pipe_we = 1; pipe_rd = 5'd7; pipe_data = 32'h00000007;
        mdu_valid = 1; mdu_rd = 5'd12; mdu_data = 32'h0000C012;
        tick();
        pipe_we = 0; mdu_rd = 5'd13; mdu_data = 32'h0000C013;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h0000C012 || fifo_count !== 3'd1) begin errors++; $display("FAIL pushpop_same: got we=%0b rd=%0d d=%h cnt=%0d want 1/12/0000c012/1", rf_we, rf_waddr, rf_wdata, fifo_count); end
        idle_inputs();
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'h0000C013 || fifo_count !== 3'd0) begin errors++; $display("FAIL pushpop_tail: got we=%0b rd=%0d d=%h cnt=%0d want 1/13/0000c013/0", rf_we, rf_waddr, rf_wdata, fifo_count); end
        tick();
        $display("push_pop: simultaneous push and pop keeps count");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1; pipe_rd = 5'(1 + i); pipe_data = 32'(i);
            mdu_valid = 1; mdu_rd = 5'(24 + i); mdu_data = 32'hE0000000 + 32'(i);
            tick();
        end
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rstmid_count: got %0d want 3", fifo_count); end
        idle_inputs();
        rst = 1;
        #1;
        checks++; if (mdu_ready !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL rstmid_comb: got ready=%0b stall=%0b want 0/0", mdu_ready, pipe_stall); end
        tick();
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL rstmid_state: got we=%0b cnt=%0d rd=%0d want 0/0/0", rf_we, fifo_count, rf_waddr); end
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_nowrite%0d: got we=%0b rd=%0d want 0", i, rf_we, rf_waddr); end
        end
        $display("reset_mid: queued entries dropped");
    endtask

    task automatic test_idle_push;
        mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 32'h12883940;
        tick();
        idle_inputs();
`ifdef WB_ARB_BYPASS_EN
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h12883940 || fifo_count !== 3'd0) begin errors++; $display("FAIL bypass_t1: got we=%0b rd=%0d d=%h cnt=%0d want 1/3/12883940/0", rf_we, rf_waddr, rf_wdata, fifo_count); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL bypass_t2: got we=%0b want 0", rf_we); end
`else
        checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd1) begin errors++; $display("FAIL idle_push_t1: got we=%0b cnt=%0d want 0/1", rf_we, fifo_count); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h12883940 || fifo_count !== 3'd0) begin errors++; $display("FAIL idle_push_t2: got we=%0b rd=%0d d=%h cnt=%0d want 1/3/12883940/0", rf_we, rf_waddr, rf_wdata, fifo_count); end
`endif
        $display("idle_push: rd3 data=12883940");
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_zero_filter();
        test_queue_drain();
        test_starvation();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_idle_push();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port behind the writeback stage. Shares it between the in-order pipeline writeback result (the WB mux output plus destination register) and a long-latency multiply/divide unit (MDU) that finishes out of order.
- Pipeline writes have priority. MDU results wait in a small FIFO and drain into idle port cycles.
- A starvation guard stalls the pipeline for one cycle when an MDU result has waited too long.

Parameters:
- DEPTH, 4, MDU result FIFO entries; power of 2, 2..16
- MAX_WAIT, 3, consecutive denied cycles before a forced grant; 1..15
- DATA_W, 32, write data width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pipe_we  in  1  WB stage requests a register write this cycle
- pipe_rd  in  5  WB destination register
- pipe_data  in  DATA_W  WB write data (WB mux output)
- mdu_valid  in  1  MDU result available
- mdu_rd  in  5  MDU destination register
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  FIFO can accept; a transfer happens when mdu_valid && mdu_ready
- pipe_stall  out  1  combinational; pipeline must hold WB this cycle; pipe_* is not consumed
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  5  registered write address
- rf_wdata  out  DATA_W  registered write data
- fifo_count  out  clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (rst=1 at clk edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO emptied, fifo_count=0, wait counter=0, state EMPTY.
  - While rst=1: mdu_ready=0 and pipe_stall=0.
  - Any entries in flight are dropped.
- Effective pipeline request: pipe_req = pipe_we && (pipe_rd != 0). Writes to $0 never reach the port.
- MDU push: occurs on mdu_valid && mdu_ready.
  - mdu_ready = !rst && (fifo_count < DEPTH).
  - A push with mdu_rd == 0 is accepted and discarded, never stored.
  - A pushed entry becomes eligible for grant the next cycle.
- FSM, on wait counter and FIFO occupancy:
  - EMPTY: fifo_count==0. Grant the pipeline if pipe_req. Go to PENDING on a push.
  - PENDING: FIFO non-empty.
    - pipe_req=1: grant the pipeline, wait counter +1.
    - pipe_req=0: pop the head and grant it, wait counter cleared.
    - Wait counter reaches MAX_WAIT: go to FORCE.
    - Last entry popped with no push: go to EMPTY.
  - FORCE: pipe_stall=1 for exactly this cycle.
    - Pop the head and grant it regardless of pipe_we. Wait counter cleared.
    - Next state PENDING if entries remain, else EMPTY.
- Grant latency: a grant at cycle t gives rf_we=1 with the matching address and data at t+1.
  - Pipeline write: 1 cycle.
  - MDU write: minimum 2 cycles (push at t, grant at t+1, rf_we at t+2).
  - No grant at t gives rf_we=0 at t+1; rf_waddr and rf_wdata hold their previous values.
- FIFO:
  - Strict arrival order; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle is legal at any occupancy below DEPTH; count is unchanged.
  - At count==DEPTH no push occurs (mdu_ready=0). A pop that cycle frees space that is visible the next cycle.
- Simultaneous events:
  - Pipeline write and MDU push in the same cycle: the pipeline is granted and the MDU entry is queued.
  - Pipeline and FIFO head targeting the same rd: the order of grants defines the final value. Keeping that order architecturally correct is the hazard unit's job, not this block's.
- Counter rule: the wait counter only counts cycles where the head is eligible and was denied.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: an MDU result may bypass the FIFO. Conditions: in EMPTY, pipe_req=0, mdu push with mdu_rd != 0. The result is granted directly in the same cycle, giving rf_we at t+1 and MDU latency 1. It is not stored and fifo_count stays 0.
- Not defined: every MDU result goes through the FIFO, minimum latency 2.

Test Plan:
- Reset then idle: after rst, rf_we=0, fifo_count=0, mdu_ready=1. Pipeline write (pipe_we=1, rd=8, data=32'h34877329) at t -> rf_we=1, waddr=8, wdata=32'h34877329 at t+1.
- $0 filtering: pipe_we=1 with rd=0, and an MDU push with rd=0 -> no rf_we, fifo_count stays 0.
- Queue and drain: pipe_we held 1 for 2 cycles while MDU pushes rd=5 (32'h12345678) and then rd=6 (32'h87654321); pipe_we then drops -> rd=5 written, then rd=6, in order; fifo_count returns to 0.
- Starvation with MAX_WAIT=3: push rd=9 (32'h748230a5), pipe_we held 1 continuously -> 3 pipeline grants, then pipe_stall=1 for one cycle and rd=9 written the next cycle. The pipeline write held during the stall is written the cycle after.
- Full FIFO: with pipe_we held 1, push 4 entries -> mdu_ready=0 and further mdu_valid is ignored. Drop pipe_we -> entries drain in order and mdu_ready=1 the cycle after the first pop.
- Reset mid-operation: 3 entries queued, assert rst -> rf_we=0 next cycle, fifo_count=0, none of the queued data is ever written. With WB_ARB_BYPASS_EN defined, an idle push of rd=3 (32'h12883940) gives rf_we at t+1.
